// File: rtl/led_bar_meter.sv
// LED bar-graph meter: sample -> bar level with periodic tick, fall hysteresis and one-segment fall per tick.
// Optional peak-hold marker under LED_BAR_PEAK_EN. Level/led follow the tick edge. No backpressure: data_vld is always accepted.
module led_bar_meter #(
  parameter int DATA_W     = 10,
  parameter int LED_NUM    = 4,
  parameter int UPD_CYCLES = 50000,
  parameter int HYST       = 8,
  parameter int HOLD_TICKS = 500
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             data_vld,
  input  logic [DATA_W-1:0]                data,
  output logic [LED_NUM-1:0]               led,
  output logic [$clog2(LED_NUM+1)-1:0]     level,
  output logic                             tick
);

  localparam int LVL_W  = $clog2(LED_NUM + 1);
  localparam int CNT_W  = (UPD_CYCLES > 1) ? $clog2(UPD_CYCLES) : 1;
  localparam int HYST_W = (HYST > 0) ? $clog2(HYST + 1) : 1;
  localparam int SUM_W  = ((HYST_W > DATA_W) ? HYST_W : DATA_W) + 1;
  localparam int PROD_W = SUM_W + LVL_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(UPD_CYCLES - 1);

  if (LED_NUM < 2 || LED_NUM > 16 || UPD_CYCLES < 1 || HYST < 0 || HOLD_TICKS < 0) begin : g_bad_param
    $error("led_bar_meter: parameter out of range");
  end

  logic [DATA_W-1:0]  sample;
  logic [CNT_W-1:0]   cnt;
  logic [SUM_W-1:0]   sum_dn;
  logic [PROD_W-1:0]  prod_up;
  logic [PROD_W-1:0]  prod_dn;
  logic [LVL_W-1:0]   t_up;
  logic [LVL_W-1:0]   t_dn;
  logic [LVL_W-1:0]   level_nx;
  logic [LED_NUM-1:0] bar;

  // 1 + (prod >> DATA_W), saturated at LED_NUM
  function automatic logic [LVL_W-1:0] seg_target(input logic [PROD_W-1:0] prod);
    logic [PROD_W-1:0] q;
    q = prod >> DATA_W;
    if (q >= PROD_W'(LED_NUM))
      return LVL_W'(LED_NUM);
    return LVL_W'(q) + LVL_W'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample <= '0;
      cnt    <= '0;
      level  <= '0;
    end else begin
      if (data_vld)
        sample <= data;
      if (cnt == CNT_LAST)
        cnt <= '0;
      else
        cnt <= cnt + CNT_W'(1);
      level <= level_nx;
    end
  end

  // Gated so that a held reset never shows a tick, even with UPD_CYCLES=1
  assign tick = ~rst & (cnt == CNT_LAST);

  always_comb begin
    sum_dn  = SUM_W'(sample) + SUM_W'(HYST);
    prod_up = PROD_W'(sample) * PROD_W'(LED_NUM);
    prod_dn = PROD_W'(sum_dn) * PROD_W'(LED_NUM);
    t_up    = seg_target(prod_up);
    t_dn    = seg_target(prod_dn);
  end

  always_comb begin
    level_nx = level;
    if (tick) begin
      if (t_up > level)
        level_nx = t_up;
      else if (t_dn < level)
        level_nx = level - LVL_W'(1);
    end
  end

  always_comb begin
    bar = '0;
    for (int i = 0; i < LED_NUM; i++)
      bar[i] = (i < int'(level));
  end

`ifdef LED_BAR_PEAK_EN
  localparam int HOLD_W = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

  logic [LVL_W-1:0]   peak;
  logic [LVL_W-1:0]   peak_dec;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [LED_NUM-1:0] peak_bit;

  assign peak_dec = peak - LVL_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak     <= '0;
      hold_cnt <= '0;
    end else if (tick) begin
      if (level_nx >= peak) begin
        peak     <= level_nx;
        hold_cnt <= HOLD_W'(HOLD_TICKS);
      end else if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - HOLD_W'(1);
      end else if (peak_dec < level_nx) begin
        peak <= level_nx;
      end else begin
        peak <= peak_dec;
      end
    end
  end

  always_comb begin
    peak_bit = '0;
    for (int i = 0; i < LED_NUM; i++)
      peak_bit[i] = (peak != '0) && (int'(peak) == i + 1);
  end

  assign led = bar | peak_bit;
`else
  assign led = bar;
`endif

endmodule

// File: tb/tb_led_bar_meter.sv
// Directed bench for led_bar_meter with a per-cycle arithmetic reference model and hand-computed checkpoints.
module tb_led_bar_meter;

  localparam int DATA_W  = 10;
  localparam int LED_NUM = 4;
  localparam int UPD     = 4;
  localparam int HYST    = 8;
  localparam int HOLD    = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              data_vld = 1'b0;
  logic [DATA_W-1:0] data = '0;
  logic [LED_NUM-1:0] led;
  logic [2:0]        level;
  logic              tick;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  led_bar_meter #(
    .DATA_W(DATA_W), .LED_NUM(LED_NUM), .UPD_CYCLES(UPD), .HYST(HYST), .HOLD_TICKS(HOLD)
  ) dut (
    .clk(clk), .rst(rst), .data_vld(data_vld), .data(data),
    .led(led), .level(level), .tick(tick)
  );

  // Reference model: plain integers following the behavioural rules
  int m_sample = 0, m_cnt = 0, m_level = 0, m_peak = 0, m_hold = 0;
  int nl, tu, td;

  function automatic int target(int s);
    int q;
    q = (s * LED_NUM) / (1 << DATA_W);
    return (q + 1 > LED_NUM) ? LED_NUM : q + 1;
  endfunction

  function automatic logic [31:0] exp_led();
    int v;
    v = (1 << m_level) - 1;
`ifdef LED_BAR_PEAK_EN
    if (m_peak > 0) v = v | (1 << (m_peak - 1));
`endif
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_sample = 0; m_cnt = 0; m_level = 0; m_peak = 0; m_hold = 0;
    end else begin
      if (m_cnt == UPD - 1) begin
        tu = target(m_sample);
        td = target(m_sample + HYST);
        nl = m_level;
        if (tu > m_level) nl = tu;
        else if (td < m_level) nl = m_level - 1;
        if (nl >= m_peak) begin
          m_peak = nl; m_hold = HOLD;
        end else if (m_hold > 0) begin
          m_hold = m_hold - 1;
        end else begin
          m_peak = (m_peak - 1 < nl) ? nl : m_peak - 1;
        end
        m_level = nl;
      end
      m_cnt = (m_cnt + 1) % UPD;
      if (data_vld) m_sample = int'(data);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model_led", 32'(led), exp_led());
    check("model_level", 32'(level), 32'(m_level));
    check("model_tick", 32'(tick), 32'(!rst && m_cnt == UPD - 1));
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send(input int d);
    data = DATA_W'(d);
    data_vld = 1'b1;
    cyc(1);
    data_vld = 1'b0;
  endtask

  task automatic to_tick();
    int k;
    k = 0;
    while (!tick && k < 2 * UPD) begin
      cyc(1);
      k++;
    end
    if (!tick) begin
      n_vec++;
      n_bad++;
      $display("FAIL to_tick: no tick within %0d cycles", 2 * UPD);
    end
  endtask

  task automatic tick_step();
    to_tick();
    cyc(1);
  endtask

  logic [3:0] fall_exp [4] = '{4'b0111, 4'b0011, 4'b0001, 4'b0001};
`ifdef LED_BAR_PEAK_EN
  logic [3:0] peak_exp [4] = '{4'b1111, 4'b1011, 4'b1001, 4'b0101};
`else
  logic [3:0] peak_exp [4] = '{4'b0111, 4'b0011, 4'b0001, 4'b0001};
`endif

  initial begin
    #1 rst = 1'b1;
    cyc(2);
    check("rst_led", 32'(led), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    rst = 1'b0;
    cyc(3);
    check("first_tick", 32'(tick), 32'd1);
    check("pre_tick_level", 32'(level), 32'd0);
    cyc(1);
    check("first_led", 32'(led), 32'b0001);

    send(700);  tick_step();
    check("rise_700", 32'(led), 32'b0111);
    send(1023); tick_step();
    check("rise_1023", 32'(led), 32'b1111);

    send(0);
    for (int i = 0; i < 4; i++) begin
      tick_step();
      check("fall_step", 32'(led), 32'(fall_exp[i]));
    end

    send(700); tick_step();
    check("hyst_setup", 32'(level), 32'd3);
    send(508);
    for (int i = 0; i < 5; i++) begin
      tick_step();
      check("hyst_hold", 32'(level), 32'd3);
    end
    send(503); tick_step();
    check("hyst_fall", 32'(level), 32'd2);
    send(600); tick_step();
    check("hyst_rise", 32'(level), 32'd3);

    send(0); tick_step(); tick_step();
    check("collide_setup", 32'(level), 32'd1);
    to_tick();
    data = 10'd1023;
    data_vld = 1'b1;
    cyc(1);
    data_vld = 1'b0;
    check("collide_old", 32'(level), 32'd1);
    tick_step();
    check("collide_new", 32'(level), 32'd4);

    send(0);
    for (int i = 0; i < 4; i++) begin
      tick_step();
      check("peak_step", 32'(led), 32'(peak_exp[i]));
    end

    cyc(1);
    rst = 1'b1;
    #1;
    check("midrst_led", 32'(led), 32'd0);
    check("midrst_level", 32'(level), 32'd0);
    check("midrst_tick", 32'(tick), 32'd0);
    cyc(2);
    rst = 1'b0;
    cyc(3);
    check("rel_tick", 32'(tick), 32'd1);
    cyc(1);
    check("rel_led", 32'(led), 32'b0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
